regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL: DATA_W, 64, register width in bits.
REQ-002 SHALL: NUM_REGS, 19, architectural register count, R0 included; legal range 2..32.
REQ-003 SHALL: ADDR_W, 5, register address width; ceil(log2(NUM_REGS)) SHALL be at most ADDR_W.
REQ-004 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL: wr1_en, wr2_en  input  1  write-port enables.
REQ-007 SHALL: wr1_addr, wr2_addr  input  ADDR_W  write addresses.
REQ-008 SHALL: wr1_data, wr2_data  input  DATA_W  write data.
REQ-009 SHALL: rd1_addr, rd2_addr  input  ADDR_W  read addresses.
REQ-010 SHALL: rd1_out, rd2_out  output  DATA_W  read data.
REQ-011 SHALL: rd1_busy, rd2_busy  output  1  scoreboard pending bit of the addressed register.
REQ-012 SHALL: issue_en  input  1  mark a destination register as pending.
REQ-013 SHALL: issue_addr  input  ADDR_W  address of the register to mark pending.
REQ-014 SHALL: busy_vec  output  NUM_REGS  full scoreboard; bit k = Rk pending.
REQ-015 SHALL: wr_conflict  output  1  registered flag; both write ports targeted the same legal non-zero address in the previous cycle.

Function
REQ-016 SHALL: storage is NUM_REGS x DATA_W flops; R0 reads 0 and has no storage.
REQ-017 SHALL: reads are combinational with zero latency; rdN_out follows rdN_addr in the same cycle.
REQ-018 SHALL: a write with wrN_en=1 to a legal non-zero address updates the register at the rising edge.
REQ-019 SHALL: writes to R0 or to any address >= NUM_REGS are discarded, with no side effect on storage or scoreboard.
REQ-020 SHALL: reads of R0 or of any address >= NUM_REGS return 0 with rdN_busy=0.
REQ-021 SHALL: when both write ports target the same legal non-zero address in one cycle, wr2_data is stored, and wr_conflict is 1 in the following cycle.
REQ-022 SHALL: when both write ports target different addresses, both writes complete in the same cycle.
REQ-023 SHALL: issue_en=1 to a legal non-zero address sets busy_vec[issue_addr] at the rising edge.
REQ-024 SHALL: a completed write to a register clears its busy bit at the rising edge.
REQ-025 SHALL: an issue and a write to the same register in the same cycle leave the bit set, because issue wins over clear.
REQ-026 SHALL: busy_vec[0] is constantly 0, and issue to R0 or to an illegal address is ignored.
REQ-027 SHALL: rdN_busy equals busy_vec[rdN_addr] as registered, with no same-cycle forwarding of issue or clear.
REQ-028 SHALL: both read ports address any register independently, including the same register.

Reset
REQ-029 SHALL: rst_n=0 asynchronously forces all registers to 0, busy_vec to 0 and wr_conflict to 0, independent of clk.
REQ-030 SHALL: while rst_n=0, rdN_out=0, rdN_busy=0, and all writes and issues are ignored.
REQ-031 SHALL: reset asserted between two clock edges aborts the write or issue in flight, so no partial update survives.
REQ-032 SHALL: after rst_n rises, the first rising edge processes writes and issues normally.

Configuration
REQ-033 SHALL: macro REGFILE_MP_BYPASS_EN defined: rdN_out returns the data being written this cycle when rdN_addr matches an active legal write (wr2 over wr1), and rdN_busy reads 0 for that register unless a same-cycle issue targets it.
REQ-034 SHALL: macro REGFILE_MP_BYPASS_EN undefined: rdN_out and rdN_busy reflect stored state only; written data is visible from the cycle after the edge.

Verification
REQ-035 SHALL: reset, then read every address 0..31 -> rd1_out=0, rd2_out=0, busy_vec=0.
REQ-036 SHALL: wr1 R3=64'h1111_2222_3333_4444 and wr2 R7=64'hAAAA_BBBB_CCCC_DDDD in the same cycle, next cycle read rd1=R3, rd2=R7 -> both values returned, wr_conflict=0.
REQ-037 SHALL: wr1 and wr2 both to R5 with data 64'h1 and 64'h2 -> R5=64'h2, wr_conflict=1 for exactly one cycle.
REQ-038 SHALL: write 64'hFFFF_FFFF_FFFF_FFFF to R0 and to address 25 -> R0 reads 0, address 25 reads 0, R1..R18 unchanged.
REQ-039 SHALL: issue R9, then wr1 R9=64'h55 with a same-cycle issue to R9, then wr1 R9=64'h66 -> busy_vec[9] is 1, stays 1, then clears to 0; R9=64'h66.
REQ-040 SHALL: with REGFILE_MP_BYPASS_EN, wr1 R4=64'hDEAD with rd1_addr=4 in the same cycle -> rd1_out=64'hDEAD before the edge; without the macro, the old value is returned before the edge and 64'hDEAD after it.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: NUM_REGS x DATA_W register file with two write ports and two read ports.
// Reads are combinational (zero latency); writes and scoreboard updates take effect at the rising edge.
// No backpressure: every port is accepted each cycle; REGFILE_MP_BYPASS_EN adds same-cycle write forwarding.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 19,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr1_en,
  input  logic [ADDR_W-1:0]   wr1_addr,
  input  logic [DATA_W-1:0]   wr1_data,
  input  logic                wr2_en,
  input  logic [ADDR_W-1:0]   wr2_addr,
  input  logic [DATA_W-1:0]   wr2_data,
  input  logic [ADDR_W-1:0]   rd1_addr,
  input  logic [ADDR_W-1:0]   rd2_addr,
  output logic [DATA_W-1:0]   rd1_out,
  output logic [DATA_W-1:0]   rd2_out,
  output logic                rd1_busy,
  output logic                rd2_busy,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wr_conflict
);

  // R0 has neither storage nor a busy bit, so every per-register vector starts at index 1.
  logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:1] wr1_hit;
  logic [NUM_REGS-1:1] wr2_hit;
  logic [NUM_REGS-1:1] iss_hit;

  // Per-port read data and busy before reset gating; index 0 is rd1, index 1 is rd2.
  logic [ADDR_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0]   rd_data [2];
  logic                rd_bsy  [2];

  assign rd_addr[0] = rd1_addr;
  assign rd_addr[1] = rd2_addr;

  // Decode write and issue addresses to one-hot; R0 and addresses >= NUM_REGS match nothing.
  always_comb begin
    wr1_hit = '0;
    wr2_hit = '0;
    iss_hit = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      wr1_hit[k] = wr1_en   && (wr1_addr   == ADDR_W'(k));
      wr2_hit[k] = wr2_en   && (wr2_addr   == ADDR_W'(k));
      iss_hit[k] = issue_en && (issue_addr == ADDR_W'(k));
    end
  end

  // Register storage: wr2 takes priority when both ports hit the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (wr2_hit[k]) begin
          regs[k] <= wr2_data;
        end else if (wr1_hit[k]) begin
          regs[k] <= wr1_data;
        end
      end
    end
  end

  // Scoreboard: an issue sets the bit and beats a same-cycle completing write, which clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (iss_hit[k]) begin
          busy_q[k] <= 1'b1;
        end else if (wr1_hit[k] || wr2_hit[k]) begin
          busy_q[k] <= 1'b0;
        end
      end
    end
  end

  // Flag a collision of both write ports on one real register, visible for the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= |(wr1_hit & wr2_hit);
    end
  end

  // Read muxes; unmatched addresses (R0, out of range) fall through to zero data and not-busy.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_bsy[p]  = 1'b0;
      for (int k = 1; k < NUM_REGS; k++) begin
        if (rd_addr[p] == ADDR_W'(k)) begin
`ifdef REGFILE_MP_BYPASS_EN
          // A write landing this cycle is forwarded, and its completion hides the busy bit
          // unless a same-cycle issue re-marks the register.
          if (wr2_hit[k]) begin
            rd_data[p] = wr2_data;
            rd_bsy[p]  = iss_hit[k];
          end else if (wr1_hit[k]) begin
            rd_data[p] = wr1_data;
            rd_bsy[p]  = iss_hit[k];
          end else begin
            rd_data[p] = regs[k];
            rd_bsy[p]  = busy_q[k];
          end
`else
          rd_data[p] = regs[k];
          rd_bsy[p]  = busy_q[k];
`endif
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held so forwarded write data never leaks out.
  assign rd1_out  = rst_n ? rd_data[0] : '0;
  assign rd2_out  = rst_n ? rd_data[1] : '0;
  assign rd1_busy = rst_n & rd_bsy[0];
  assign rd2_busy = rst_n & rd_bsy[1];
  assign busy_vec = {busy_q, 1'b0};

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed vectors with hand-computed expectations.
// Stimulus pushes the expected outputs of each cycle into a queue; a negedge monitor pops and compares.
// Expectations account for the REGFILE_MP_BYPASS_EN build through the BYP constant.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [63:0] V3   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] V7   = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        wr1_en, wr2_en, issue_en;
  logic [4:0]  wr1_addr, wr2_addr, rd1_addr, rd2_addr, issue_addr;
  logic [63:0] wr1_data, wr2_data;
  logic [63:0] rd1_out, rd2_out;
  logic        rd1_busy, rd2_busy;
  logic [18:0] busy_vec;
  logic        wr_conflict;

  typedef struct {
    string       tag;
    logic [63:0] r1;
    logic [63:0] r2;
    logic        b1;
    logic        b2;
    logic [18:0] bv;
    logic        wc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_mp #(.DATA_W(64), .NUM_REGS(19), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_out(rd1_out), .rd2_out(rd2_out),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_vec(busy_vec), .wr_conflict(wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", tag, field, act, want);
    end
  endtask

  // Monitor: compare outputs mid-cycle against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "rd1_out",     rd1_out,             e.r1);
      chk(e.tag, "rd2_out",     rd2_out,             e.r2);
      chk(e.tag, "rd1_busy",    64'(rd1_busy),       64'(e.b1));
      chk(e.tag, "rd2_busy",    64'(rd2_busy),       64'(e.b2));
      chk(e.tag, "busy_vec",    64'(busy_vec),       64'(e.bv));
      chk(e.tag, "wr_conflict", 64'(wr_conflict),    64'(e.wc));
    end
  end

  task automatic push(input string tag, input logic [63:0] r1, input logic [63:0] r2,
                      input logic b1, input logic b2, input logic [18:0] bv, input logic wc);
    exp_t e;
    e.tag = tag; e.r1 = r1; e.r2 = r2; e.b1 = b1; e.b2 = b2; e.bv = bv; e.wc = wc;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    wr2_en = 1'b0; wr2_addr = '0; wr2_data = '0;
    issue_en = 1'b0; issue_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] reg_after_writes(input int k);
    case (k)
      3:       return V3;
      5:       return 64'h2;
      7:       return V7;
      default: return 64'h0;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    rd1_addr = '0;
    rd2_addr = '0;
    tick();

    // Writes and issues driven during reset must not land or show.
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = V3;
    issue_en = 1'b1; issue_addr = 5'd3;
    rd1_addr = 5'd3; rd2_addr = 5'd7;
    push("in_reset", 64'h0, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();

    rst_n = 1'b1;
    idle();
    for (int a = 0; a < 32; a++) begin
      rd1_addr = 5'(a);
      rd2_addr = 5'(31 - a);
      push("reset_read", 64'h0, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
      tick();
    end

    // Dual write to distinct registers.
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = V3;
    wr2_en = 1'b1; wr2_addr = 5'd7; wr2_data = V7;
    rd1_addr = 5'd3; rd2_addr = 5'd7;
    push("pair_pre", BYP ? V3 : 64'h0, BYP ? V7 : 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    idle();
    push("pair_post", V3, V7, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();

    // Same-register collision: wr2 wins, conflict flag for one cycle.
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 64'h1;
    wr2_en = 1'b1; wr2_addr = 5'd5; wr2_data = 64'h2;
    rd1_addr = 5'd5; rd2_addr = 5'd5;
    push("same_pre", BYP ? 64'h2 : 64'h0, BYP ? 64'h2 : 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    idle();
    rd2_addr = 5'd3;
    push("same_post", 64'h2, V3, 1'b0, 1'b0, 19'h0, 1'b1);
    tick();
    push("conflict_drop", 64'h2, V3, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();

    // Writes to R0 and to an out-of-range address are discarded.
    wr1_en = 1'b1; wr1_addr = 5'd0;  wr1_data = ONES;
    wr2_en = 1'b1; wr2_addr = 5'd25; wr2_data = ONES;
    rd1_addr = 5'd0; rd2_addr = 5'd25;
    push("illegal_pre", 64'h0, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    wr1_addr = 5'd25;
    push("illegal_same", 64'h0, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    idle();
    push("illegal_post", 64'h0, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    for (int k = 1; k < 19; k++) begin
      rd1_addr = 5'(k);
      rd2_addr = 5'(k);
      push("regs_intact", reg_after_writes(k), reg_after_writes(k), 1'b0, 1'b0, 19'h0, 1'b0);
      tick();
    end

    // Scoreboard: issue, write+issue keeps busy, plain write clears.
    issue_en = 1'b1; issue_addr = 5'd9;
    rd1_addr = 5'd9; rd2_addr = 5'd0;
    push("issue_pre", 64'h0, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'h55;
    push("issue_wr", BYP ? 64'h55 : 64'h0, 64'h0, 1'b1, 1'b0, 19'h200, 1'b0);
    tick();
    issue_en = 1'b0; wr1_data = 64'h66;
    push("wr_clear_pre", BYP ? 64'h66 : 64'h55, 64'h0, BYP ? 1'b0 : 1'b1, 1'b0, 19'h200, 1'b0);
    tick();
    idle();
    push("busy_cleared", 64'h66, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();

    // Issues to R0 and to an illegal address are ignored.
    issue_en = 1'b1; issue_addr = 5'd0;
    push("iss_r0", 64'h66, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    issue_addr = 5'd20;
    push("iss_ill", 64'h66, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    idle();
    push("iss_ignored", 64'h66, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();

    // Write port 2 also clears the busy bit.
    issue_en = 1'b1; issue_addr = 5'd2;
    rd1_addr = 5'd2; rd2_addr = 5'd9;
    push("iss2", 64'h0, 64'h66, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    idle();
    wr2_en = 1'b1; wr2_addr = 5'd2; wr2_data = 64'h77;
    push("wr2_clr_pre", BYP ? 64'h77 : 64'h0, 64'h66, BYP ? 1'b0 : 1'b1, 1'b0, 19'h4, 1'b0);
    tick();
    idle();
    push("wr2_clr", 64'h77, 64'h66, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();

    // Read-during-write visibility.
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 64'hDEAD;
    rd1_addr = 5'd4; rd2_addr = 5'd2;
    push("byp_pre", BYP ? 64'hDEAD : 64'h0, 64'h77, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    idle();
    push("byp_post", 64'hDEAD, 64'h77, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();

    // Reset asserted mid-cycle aborts the pending write and issue and clears state at once.
    wr1_en = 1'b1; wr1_addr = 5'd6; wr1_data = 64'h1234;
    issue_en = 1'b1; issue_addr = 5'd10;
    rd1_addr = 5'd6; rd2_addr = 5'd4;
    #2;
    rst_n = 1'b0;
    push("rst_mid", 64'h0, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    idle();
    rd1_addr = 5'd6; rd2_addr = 5'd9;
    push("rst_abort", 64'h0, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();

    // First edge after reset release processes writes normally.
    wr1_en = 1'b1; wr1_addr = 5'd1; wr1_data = 64'hABC;
    rd1_addr = 5'd1; rd2_addr = 5'd4;
    push("post_rst_pre", BYP ? 64'hABC : 64'h0, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();
    idle();
    push("post_rst", 64'hABC, 64'h0, 1'b0, 1'b0, 19'h0, 1'b0);
    tick();

    // Drain: the monitor must consume every expectation within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
